// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter that lets NREQ producers share the single write
//   port of a synchronous FIFO. The winning producer owns the port for one
//   burst, which ends on a beat flagged with req_last or after MAX_BURST beats.
//   Every grant costs one arbitration cycle in IDLE before beats can flow.
//
// Ports
//   clk         single clock, all logic on posedge
//   rst         synchronous reset, active-high
//   req_valid   per-requester beat valid
//   req_data    per-requester data, requester i at [i*WIDTH +: WIDTH]
//   req_last    per-requester end-of-burst flag for the current beat
//   req_ready   per-requester accept; a beat moves when valid & ready
//   fifo_wdata  write data to the FIFO
//   fifo_wpush  write strobe to the FIFO
//   fifo_wfull  full flag from the FIFO
//   grant_id    index of the current owner, meaningful only while busy
//   busy        high while a requester owns the write port

module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    input  logic [NREQ-1:0]           req_last,
    output logic [NREQ-1:0]           req_ready,
    output logic [WIDTH-1:0]          fifo_wdata,
    output logic                      fifo_wpush,
    input  logic                      fifo_wfull,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [CW-1:0]    beat_cnt;

    logic             pick_valid;
    logic [IDW-1:0]   pick_idx;
    logic [IDW:0]     pick_sum;
    logic [2*NREQ-1:0] valid_dbl;
    logic [NREQ-1:0]  valid_rot;

    logic [WIDTH-1:0] sel_data;
    logic             sel_valid;
    logic             sel_last;
    logic             own;
    logic             burst_end;
    logic [IDW-1:0]   next_ptr;

    // Round-robin pick: rotate the valid vector so rr_ptr lands on bit 0,
    // take the lowest set bit, then add rr_ptr back modulo NREQ. Doubling the
    // vector before the shift gives the cyclic wrap for free.
    always_comb begin
        valid_dbl  = {req_valid, req_valid};
        valid_rot  = NREQ'(valid_dbl >> rr_ptr);
        pick_valid = 1'b0;
        pick_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_valid && valid_rot[k]) begin
                pick_valid = 1'b1;
                pick_sum   = (IDW+1)'(rr_ptr) + (IDW+1)'(k);
            end
        end
        if (pick_sum >= (IDW+1)'(NREQ)) begin
            pick_sum = pick_sum - (IDW+1)'(NREQ);
        end
        pick_idx = pick_sum[IDW-1:0];
    end

    // Owner-side view: select the granted requester's valid/data/last and
    // decide the handshake. Everything is gated by rst so the FIFO and the
    // producers see a quiet interface for the whole reset cycle.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_data  = req_data[i*WIDTH +: WIDTH];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
            end
        end

        own        = (state == OWN) && !rst;
        fifo_wpush = own && sel_valid && !fifo_wfull;
        fifo_wdata = own ? sel_data : '0;

        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = own && !fifo_wfull && (grant_id == IDW'(i));
        end

        burst_end = sel_last || (beat_cnt == CW'(MAX_BURST - 1));
        next_ptr  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end

    assign busy = (state == OWN) && !rst;

    // Grant FSM. IDLE spends exactly one cycle latching the round-robin winner;
    // OWN counts accepted beats and hands the pointer to the next index when
    // the burst closes. A stalled owner simply holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    if (fifo_wpush) begin
                        beat_cnt <= beat_cnt + CW'(1);
                        if (burst_end) begin
                            state  <= IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter with NREQ=4, WIDTH=16, MAX_BURST=4 in
//   front of a behavioural FIFO of depth 8. Walks through reset, round-robin
//   order, burst capping, full-FIFO stall, owner stall fairness and a reset
//   in the middle of a burst.

module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 16;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_last;
    logic [WIDTH-1:0]   req_d [NREQ];
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [WIDTH-1:0]   fifo_wdata;
    logic               fifo_wpush;
    logic               fifo_wfull;
    logic [1:0]         grant_id;
    logic               busy;

    logic [WIDTH-1:0]   fifo_q [$];
    int                 fifo_count = 0;
    int                 overflow   = 0;
    logic               fifo_pop   = 1'b0;
    logic               fifo_flush = 1'b0;
    logic [WIDTH-1:0]   pop_data   = '0;

    int                 errors = 0;
    int                 checks = 0;
    int                 cyc;

    assign req_data   = {req_d[3], req_d[2], req_d[1], req_d[0]};
    assign fifo_wfull = (fifo_count == DEPTH);

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_wdata (fifo_wdata),
        .fifo_wpush (fifo_wpush),
        .fifo_wfull (fifo_wfull),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    // Behavioural downstream FIFO: records every push in order, pops on
    // request, and counts any push that arrives while it reports full.
    always @(posedge clk) begin
        if (fifo_flush) begin
            fifo_q.delete();
            fifo_count <= 0;
        end else begin
            if (fifo_wpush && fifo_wfull) overflow <= overflow + 1;
            if (fifo_pop && fifo_q.size() > 0) pop_data <= fifo_q.pop_front();
            if (fifo_wpush) fifo_q.push_back(fifo_wdata);
            fifo_count <= fifo_q.size();
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l);
        @(negedge clk);
        req_valid = v;
        req_last  = l;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = '0;
        req_last   = '0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        fifo_flush = 1'b0;
    endtask

    function automatic logic last_for(input int k, input int every);
        if (every == 0) return 1'b0;
        return ((k + 1) % every) == 0;
    endfunction

    // Producer r offers n beats first, first+1, ...; advances only on an
    // accepted beat and drops valid after the last one. cyc_out counts the
    // cycles spent, bounded by budget.
    task automatic stream_beats(input logic [1:0] r, input logic [15:0] first, input int n,
                                input int every, input int budget, output int cyc_out);
        int   k;
        logic acc;
        k       = 0;
        cyc_out = 0;
        @(negedge clk);
        req_d[r]     = first;
        req_last[r]  = last_for(0, every);
        req_valid[r] = 1'b1;
        while (k < n && cyc_out < budget) begin
            #1;
            acc = req_ready[r];
            @(negedge clk);
            cyc_out++;
            if (acc) begin
                k++;
                if (k < n) begin
                    req_d[r]    = first + 16'(k);
                    req_last[r] = last_for(k, every);
                end else begin
                    req_valid[r] = 1'b0;
                    req_last[r]  = 1'b0;
                end
            end
        end
        checkOutput("stream_done", 32'(k), 32'(n));
    endtask

    initial begin
        // Reset held with every requester valid
        rst        = 1'b1;
        req_valid  = 4'b1111;
        req_last   = 4'b1111;
        fifo_flush = 1'b1;
        for (int i = 0; i < NREQ; i++) req_d[i] = 16'hA000 + 16'(i);
        #1;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_ready", 32'(req_ready), 0);
        checkOutput("rst_wpush", 32'(fifo_wpush), 0);
        checkOutput("rst_wdata", 32'(fifo_wdata), 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            checkOutput("rst_busy", 32'(busy), 0);
            checkOutput("rst_ready", 32'(req_ready), 0);
            checkOutput("rst_wpush", 32'(fifo_wpush), 0);
            checkOutput("rst_wdata", 32'(fifo_wdata), 0);
        end
        rst        = 1'b0;
        fifo_flush = 1'b0;

        // Round robin, one last-flagged beat each
        $display("[TB] round robin");
        applyStimulus(4'b1111, 4'b1111);
        checkOutput("rr_g0_busy", 32'(busy), 1);
        checkOutput("rr_g0_id", 32'(grant_id), 0);
        checkOutput("rr_g0_ready", 32'(req_ready), 'b0001);
        checkOutput("rr_g0_push", 32'(fifo_wpush), 1);
        checkOutput("rr_g0_data", 32'(fifo_wdata), 'hA000);
        applyStimulus(4'b1110, 4'b1111);
        checkOutput("rr_bubble0", 32'(fifo_wpush), 0);
        checkOutput("rr_bubble0_busy", 32'(busy), 0);
        applyStimulus(4'b1110, 4'b1111);
        checkOutput("rr_g1_id", 32'(grant_id), 1);
        checkOutput("rr_g1_ready", 32'(req_ready), 'b0010);
        checkOutput("rr_g1_data", 32'(fifo_wdata), 'hA001);
        applyStimulus(4'b1100, 4'b1111);
        checkOutput("rr_bubble1", 32'(fifo_wpush), 0);
        applyStimulus(4'b1100, 4'b1111);
        checkOutput("rr_g2_id", 32'(grant_id), 2);
        checkOutput("rr_g2_data", 32'(fifo_wdata), 'hA002);
        applyStimulus(4'b1000, 4'b1111);
        checkOutput("rr_bubble2", 32'(fifo_wpush), 0);
        applyStimulus(4'b1000, 4'b1111);
        checkOutput("rr_g3_id", 32'(grant_id), 3);
        checkOutput("rr_g3_data", 32'(fifo_wdata), 'hA003);
        req_d[0] = 16'hA010;
        applyStimulus(4'b1001, 4'b1111);
        checkOutput("rr_bubble3", 32'(fifo_wpush), 0);
        applyStimulus(4'b1001, 4'b1111);
        checkOutput("rr_wrap_id", 32'(grant_id), 0);
        checkOutput("rr_wrap_data", 32'(fifo_wdata), 'hA010);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("rr_fifo_size", fifo_q.size(), 5);
        if (fifo_q.size() == 5) begin
            checkOutput("rr_q0", 32'(fifo_q[0]), 'hA000);
            checkOutput("rr_q1", 32'(fifo_q[1]), 'hA001);
            checkOutput("rr_q2", 32'(fifo_q[2]), 'hA002);
            checkOutput("rr_q3", 32'(fifo_q[3]), 'hA003);
            checkOutput("rr_q4", 32'(fifo_q[4]), 'hA010);
        end

        // Burst cap: 6 beats, no last, from requester 2 alone
        $display("[TB] burst cap");
        do_reset();
        stream_beats(2'd2, 16'h0201, 6, 0, 30, cyc);
        checkOutput("cap_cycles", 32'(cyc), 8);
        checkOutput("cap_fifo_size", fifo_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < fifo_q.size()) checkOutput("cap_q", 32'(fifo_q[i]), 'h201 + i);
        end
        #1;
        checkOutput("cap_still_busy", 32'(busy), 1);
        checkOutput("cap_still_id", 32'(grant_id), 2);

        // Full FIFO stall with no pops
        $display("[TB] full stall");
        do_reset();
        stream_beats(2'd1, 16'h0100, 8, 4, 40, cyc);
        checkOutput("full_cycles", 32'(cyc), 10);
        checkOutput("full_count", 32'(fifo_count), 8);
        checkOutput("full_flag", 32'(fifo_wfull), 1);
        @(negedge clk);
        req_d[1]     = 16'h0108;
        req_last[1]  = 1'b0;
        req_valid[1] = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("full_busy", 32'(busy), 1);
        checkOutput("full_id", 32'(grant_id), 1);
        checkOutput("full_ready", 32'(req_ready), 0);
        checkOutput("full_push", 32'(fifo_wpush), 0);
        checkOutput("full_data_held", 32'(fifo_wdata), 'h0108);
        @(negedge clk);
        fifo_pop = 1'b1;
        #1;
        checkOutput("full_push_still0", 32'(fifo_wpush), 0);
        @(negedge clk);
        fifo_pop = 1'b0;
        #1;
        checkOutput("full_pop0", 32'(pop_data), 'h0100);
        checkOutput("full_resume_ready", 32'(req_ready), 'b0010);
        checkOutput("full_resume_push", 32'(fifo_wpush), 1);
        checkOutput("full_resume_data", 32'(fifo_wdata), 'h0108);
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1;
        checkOutput("full_count_again", 32'(fifo_count), 8);
        checkOutput("full_owner_kept", 32'(busy), 1);
        fifo_pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            checkOutput("full_pop_order", 32'(pop_data), 'h101 + i);
        end
        fifo_pop = 1'b0;
        stream_beats(2'd1, 16'h0109, 1, 1, 10, cyc);
        checkOutput("full_tail_cycles", 32'(cyc), 1);
        checkOutput("full_tail_count", 32'(fifo_count), 1);
        if (fifo_q.size() == 1) checkOutput("full_tail_data", 32'(fifo_q[0]), 'h0109);
        #1;
        checkOutput("full_tail_idle", 32'(busy), 0);

        // Owner stalls mid-burst while requester 3 waits
        $display("[TB] owner stall");
        do_reset();
        @(negedge clk);
        req_d[0]  = 16'h0500;
        req_d[3]  = 16'h0300;
        req_last  = 4'b1000;
        req_valid = 4'b1001;
        @(negedge clk);
        #1;
        checkOutput("stall_id", 32'(grant_id), 0);
        checkOutput("stall_data0", 32'(fifo_wdata), 'h0500);
        checkOutput("stall_push0", 32'(fifo_wpush), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 4'b1000;
            #1;
            checkOutput("stall_hold_id", 32'(grant_id), 0);
            checkOutput("stall_hold_push", 32'(fifo_wpush), 0);
            checkOutput("stall_hold_ready", 32'(req_ready), 'b0001);
        end
        @(negedge clk);
        req_d[0]  = 16'h0501;
        req_last  = 4'b1001;
        req_valid = 4'b1001;
        #1;
        checkOutput("stall_last_push", 32'(fifo_wpush), 1);
        checkOutput("stall_last_data", 32'(fifo_wdata), 'h0501);
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        checkOutput("stall_bubble", 32'(busy), 0);
        @(negedge clk);
        #1;
        checkOutput("stall_next_id", 32'(grant_id), 3);
        checkOutput("stall_next_data", 32'(fifo_wdata), 'h0300);
        checkOutput("stall_next_push", 32'(fifo_wpush), 1);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checkOutput("stall_done_busy", 32'(busy), 0);
        checkOutput("stall_fifo_size", fifo_q.size(), 3);
        if (fifo_q.size() == 3) begin
            checkOutput("stall_q0", 32'(fifo_q[0]), 'h0500);
            checkOutput("stall_q1", 32'(fifo_q[1]), 'h0501);
            checkOutput("stall_q2", 32'(fifo_q[2]), 'h0300);
        end

        // Reset in the middle of a burst from requester 1
        $display("[TB] reset mid-burst");
        do_reset();
        stream_beats(2'd0, 16'h0610, 1, 1, 10, cyc);
        checkOutput("mid_pre_cycles", 32'(cyc), 2);
        stream_beats(2'd1, 16'h0600, 2, 0, 10, cyc);
        checkOutput("mid_two_cycles", 32'(cyc), 3);
        @(negedge clk);
        rst          = 1'b1;
        req_d[1]     = 16'h0602;
        req_valid[1] = 1'b1;
        #1;
        checkOutput("mid_rst_push", 32'(fifo_wpush), 0);
        checkOutput("mid_rst_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst       = 1'b0;
        req_d[0]  = 16'h0620;
        req_d[3]  = 16'h0630;
        req_last  = 4'b1001;
        req_valid = 4'b1001;
        #1;
        checkOutput("mid_after_busy", 32'(busy), 0);
        checkOutput("mid_after_push", 32'(fifo_wpush), 0);
        @(negedge clk);
        #1;
        checkOutput("mid_restart_id", 32'(grant_id), 0);
        checkOutput("mid_restart_data", 32'(fifo_wdata), 'h0620);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checkOutput("mid_fifo_size", fifo_q.size(), 4);
        if (fifo_q.size() == 4) begin
            checkOutput("mid_q0", 32'(fifo_q[0]), 'h0610);
            checkOutput("mid_q1", 32'(fifo_q[1]), 'h0600);
            checkOutput("mid_q2", 32'(fifo_q[2]), 'h0601);
            checkOutput("mid_q3", 32'(fifo_q[3]), 'h0620);
        end

        checkOutput("no_push_while_full", 32'(overflow), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
